// File: rtl/frame_strobe_seq_pkg.sv
// Shared types and default sizing for the frame strobe sequencer.
package frame_strobe_seq_pkg;

  localparam int DefMaxFramesPerCol = 20;
  localparam int DefFrameBitsPerRow = 32;
  localparam int DefFrameIdxWidth   = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/frame_strobe_dec.sv
// Combinational frame index to one-hot decoder; out-of-range indices decode to all-zero.
module frame_strobe_dec #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameIdxWidth   = 5
) (
  input  logic [FrameIdxWidth-1:0]   idx,
  output logic [MaxFramesPerCol-1:0] onehot,
  output logic                       in_range
);

  // Compare in 32 bits so MaxFramesPerCol == 2**FrameIdxWidth does not wrap.
  assign in_range = (32'(idx) < 32'(MaxFramesPerCol));

  always_comb begin
    onehot = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      onehot[i] = (32'(idx) == 32'(i));
    end
  end

endmodule

// File: rtl/frame_strobe_seq.sv
// Frame write sequencer: one request -> SETUP, StrobeWidth cycles of one-hot strobe, HOLD.
// Optional macro FRAME_STROBE_RANGE_CHECK_EN enables the sticky out-of-range err flag.
//
// state     | meaning
// ST_IDLE   | ready for a request, FrameData keeps last word
// ST_SETUP  | FrameData presented, strobe low
// ST_STROBE | selected strobe bit high for StrobeWidth cycles
// ST_HOLD   | strobe low, data held one more cycle
module frame_strobe_seq
  import frame_strobe_seq_pkg::*;
#(
  parameter int MaxFramesPerCol = DefMaxFramesPerCol,
  parameter int FrameBitsPerRow = DefFrameBitsPerRow,
  parameter int StrobeWidth     = 2,
  parameter int FrameIdxWidth   = DefFrameIdxWidth
) (
  input  logic                       UserCLK,
  input  logic                       Reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [FrameIdxWidth-1:0]   req_frame,
  input  logic [FrameBitsPerRow-1:0] req_data,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err
);

  if (StrobeWidth < 1) begin : g_bad_strobe_width
    $error("frame_strobe_seq: StrobeWidth must be at least 1");
  end
  if ((2 ** FrameIdxWidth) < MaxFramesPerCol) begin : g_bad_idx_width
    $error("frame_strobe_seq: FrameIdxWidth too narrow for MaxFramesPerCol");
  end

  localparam int CntWidth = $clog2(StrobeWidth + 1);
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(StrobeWidth);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(1);

  state_e                     state;
  logic [CntWidth-1:0]        strobe_cnt;
  logic [MaxFramesPerCol-1:0] frame_sel;
  logic [MaxFramesPerCol-1:0] dec_onehot;
  logic                       dec_in_range;
  logic                       handshake;

  frame_strobe_dec #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .FrameIdxWidth  (FrameIdxWidth)
  ) u_dec (
    .idx     (req_frame),
    .onehot  (dec_onehot),
    .in_range(dec_in_range)
  );

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign handshake = req_valid & req_ready;

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state       <= ST_IDLE;
      strobe_cnt  <= '0;
      frame_sel   <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            FrameData <= req_data;
            frame_sel <= dec_in_range ? dec_onehot : '0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          FrameStrobe <= frame_sel;
          strobe_cnt  <= CntLoad;
          state       <= ST_STROBE;
        end
        ST_STROBE: begin
          if (strobe_cnt == CntLast) begin
            FrameStrobe <= '0;
            state       <= ST_HOLD;
          end else begin
            strobe_cnt <= strobe_cnt - CntLast;
          end
        end
        ST_HOLD: begin
          state <= ST_IDLE;
        end
        default: begin
          FrameStrobe <= '0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FRAME_STROBE_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else if (handshake && !dec_in_range) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_strobe_seq.sv
// Self-checking bench for frame_strobe_seq: vector table plus hand sequences, scoreboard queue.
module tb_frame_strobe_seq;

  logic        UserCLK = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_frame = '0;
  logic [31:0] req_data = '0;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        busy;
  logic        err;

`ifdef FRAME_STROBE_RANGE_CHECK_EN
  localparam logic ErrOor = 1'b1;
`else
  localparam logic ErrOor = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  frame_strobe_seq #(
    .MaxFramesPerCol(20),
    .FrameBitsPerRow(32),
    .StrobeWidth    (2),
    .FrameIdxWidth  (5)
  ) dut (
    .UserCLK    (UserCLK),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_frame  (req_frame),
    .req_data   (req_data),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .busy       (busy),
    .err        (err)
  );

  always #5 UserCLK = ~UserCLK;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [4:0]  frame;
    logic [31:0] data;
    logic [19:0] es;
    logic [31:0] ed;
    logic        er;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [19:0] es;
    logic [31:0] ed;
    logic        er;
    logic        ee;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic void add(input logic rst, input logic valid, input logic [4:0] frame,
                              input logic [31:0] data, input logic [19:0] es,
                              input logic [31:0] ed, input logic er, input logic ee);
    vec_t v;
    v.rst = rst; v.valid = valid; v.frame = frame; v.data = data;
    v.es = es; v.ed = ed; v.er = er; v.ee = ee;
    vecs.push_back(v);
  endfunction

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, record expected post-edge outputs, then compare after the edge.
  task automatic step(input logic rst, input logic valid, input logic [4:0] frame,
                      input logic [31:0] data, input logic [19:0] es, input logic [31:0] ed,
                      input logic er, input logic ee, input string name);
    exp_t e;
    Reset = rst; req_valid = valid; req_frame = frame; req_data = data;
    e.es = es; e.ed = ed; e.er = er; e.ee = ee; e.name = name;
    exp_q.push_back(e);
    @(posedge UserCLK);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (FrameStrobe !== e.es) begin
      errors++;
      $display("FAIL %s strobe: got %05h expected %05h", e.name, FrameStrobe, e.es);
    end
    checks++;
    if (FrameData !== e.ed) begin
      errors++;
      $display("FAIL %s data: got %08h expected %08h", e.name, FrameData, e.ed);
    end
    check_bit({e.name, " ready"}, req_ready, e.er);
    check_bit({e.name, " busy"}, busy, ~e.er);
    check_bit({e.name, " err"}, err, e.ee);
  endtask

  // Continuous invariants, sampled on the inactive edge.
  always @(negedge UserCLK) begin
    checks++;
    if ($countones(FrameStrobe) > 1) begin
      errors++;
      $display("FAIL onehot: strobe %05h has more than one bit", FrameStrobe);
    end
    checks++;
    if (req_ready !== !busy) begin
      errors++;
      $display("FAIL ready_busy: ready %0b busy %0b", req_ready, busy);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    add(1, 0, 0,  32'h0,         20'h0,     32'h0,         1, 0);
    // Basic write to frame 3
    add(0, 1, 3,  32'hA5A5_0F0F, 20'h0,     32'hA5A5_0F0F, 0, 0);
    add(0, 0, 0,  32'h0,         20'h00008, 32'hA5A5_0F0F, 0, 0);
    add(0, 0, 0,  32'h0,         20'h00008, 32'hA5A5_0F0F, 0, 0);
    add(0, 0, 0,  32'h0,         20'h0,     32'hA5A5_0F0F, 0, 0);
    add(0, 0, 0,  32'h0,         20'h0,     32'hA5A5_0F0F, 1, 0);
    add(0, 0, 0,  32'h0,         20'h0,     32'hA5A5_0F0F, 1, 0);
    // valid held high: frame 0, then frame 19 accepted five edges later
    add(0, 1, 0,  32'hD000_0000, 20'h0,     32'hD000_0000, 0, 0);
    add(0, 1, 19, 32'hD000_0019, 20'h00001, 32'hD000_0000, 0, 0);
    add(0, 1, 19, 32'hD000_0019, 20'h00001, 32'hD000_0000, 0, 0);
    add(0, 1, 19, 32'hD000_0019, 20'h0,     32'hD000_0000, 0, 0);
    add(0, 1, 19, 32'hD000_0019, 20'h0,     32'hD000_0000, 1, 0);
    add(0, 1, 19, 32'hD000_0019, 20'h0,     32'hD000_0019, 0, 0);
    add(0, 0, 0,  32'h0,         20'h80000, 32'hD000_0019, 0, 0);
    add(0, 0, 0,  32'h0,         20'h80000, 32'hD000_0019, 0, 0);
    add(0, 0, 0,  32'h0,         20'h0,     32'hD000_0019, 0, 0);
    add(0, 0, 0,  32'h0,         20'h0,     32'hD000_0019, 1, 0);
    // Out-of-range frame 25
    add(0, 1, 25, 32'h1234_5678, 20'h0,     32'h1234_5678, 0, ErrOor);
    add(0, 0, 0,  32'h0,         20'h0,     32'h1234_5678, 0, ErrOor);
    add(0, 0, 0,  32'h0,         20'h0,     32'h1234_5678, 0, ErrOor);
    add(0, 0, 0,  32'h0,         20'h0,     32'h1234_5678, 0, ErrOor);
    add(0, 0, 0,  32'h0,         20'h0,     32'h1234_5678, 1, ErrOor);
    add(0, 0, 0,  32'h0,         20'h0,     32'h1234_5678, 1, ErrOor);
    // Reset clears err and data; reset wins over a simultaneous handshake
    add(1, 1, 5,  32'hBEEF_0005, 20'h0,     32'h0,         1, 0);
    add(0, 0, 5,  32'hBEEF_0005, 20'h0,     32'h0,         1, 0);
    add(0, 0, 0,  32'h0,         20'h0,     32'h0,         1, 0);
    // Max in-range index 19 with idle gap before it
    add(0, 1, 19, 32'h0000_0013, 20'h0,     32'h0000_0013, 0, 0);
    add(0, 0, 0,  32'h0,         20'h80000, 32'h0000_0013, 0, 0);
    add(0, 0, 0,  32'h0,         20'h80000, 32'h0000_0013, 0, 0);
    add(0, 0, 0,  32'h0,         20'h0,     32'h0000_0013, 0, 0);
    add(0, 0, 0,  32'h0,         20'h0,     32'h0000_0013, 1, 0);
    // Index 20 is the first out-of-range value
    add(0, 1, 20, 32'h0000_0014, 20'h0,     32'h0000_0014, 0, ErrOor);
    add(0, 0, 0,  32'h0,         20'h0,     32'h0000_0014, 0, ErrOor);
    add(0, 0, 0,  32'h0,         20'h0,     32'h0000_0014, 0, ErrOor);
    add(0, 0, 0,  32'h0,         20'h0,     32'h0000_0014, 0, ErrOor);
    add(0, 0, 0,  32'h0,         20'h0,     32'h0000_0014, 1, ErrOor);
    add(1, 0, 0,  32'h0,         20'h0,     32'h0,         1, 0);

    #2;
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].valid, vecs[i].frame, vecs[i].data,
           vecs[i].es, vecs[i].ed, vecs[i].er, vecs[i].ee, $sformatf("vec%0d", i));
    end

    // Reset on the second strobe edge of a write to frame 7
    step(0, 1, 7, 32'h0000_0777, 20'h0,     32'h0000_0777, 0, 0, "abort_setup");
    step(0, 0, 0, 32'h0,         20'h00080, 32'h0000_0777, 0, 0, "abort_strobe1");
    step(1, 0, 0, 32'h0,         20'h0,     32'h0,         1, 0, "abort_reset");
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 32'h0, 20'h0, 32'h0, 1, 0, $sformatf("abort_quiet%0d", i));
    end

    // Reset asserted during SETUP, with valid also high on that edge
    step(0, 1, 2,  32'h0000_0222, 20'h0,     32'h0000_0222, 0, 0, "rst_setup_hs");
    step(1, 1, 4,  32'h0000_0444, 20'h0,     32'h0,         1, 0, "rst_setup");
    step(0, 0, 4,  32'h0000_0444, 20'h0,     32'h0,         1, 0, "rst_setup_idle");

    // Frame 0 after reset sanity, with data held in IDLE afterwards
    step(0, 1, 0,  32'hCAFE_F00D, 20'h0,     32'hCAFE_F00D, 0, 0, "f0_setup");
    step(0, 0, 0,  32'h0,         20'h00001, 32'hCAFE_F00D, 0, 0, "f0_strobe1");
    step(0, 0, 0,  32'h0,         20'h00001, 32'hCAFE_F00D, 0, 0, "f0_strobe2");
    step(0, 0, 0,  32'h0,         20'h0,     32'hCAFE_F00D, 0, 0, "f0_hold");
    step(0, 0, 0,  32'h0,         20'h0,     32'hCAFE_F00D, 1, 0, "f0_idle");
    step(0, 0, 0,  32'h0,         20'h0,     32'hCAFE_F00D, 1, 0, "f0_idle2");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_strobe_seq.md
FRAME_STROBE_SEQ -- requirements
Module: frame_strobe_seq

Interface
REQ-001 Parameter MaxFramesPerCol, default 20: width of FrameStrobe, number of frames per column.
REQ-002 Parameter FrameBitsPerRow, default 32: width of frame data word.
REQ-003 Parameter StrobeWidth, default 2: cycles FrameStrobe is held high per write; values below 1 SHALL fail elaboration.
REQ-004 Parameter FrameIdxWidth, default 5: width of req_frame; SHALL satisfy 2**FrameIdxWidth >= MaxFramesPerCol.
REQ-005 UserCLK  input  1  single clock; all state updates on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  frame-write request present.
REQ-008 req_ready  output  1  sequencer can accept a request.
REQ-009 req_frame  input  FrameIdxWidth  target frame index.
REQ-010 req_data  input  FrameBitsPerRow  configuration word for that frame.
REQ-011 FrameData  output  FrameBitsPerRow  registered data toward the tile column.
REQ-012 FrameStrobe  output  MaxFramesPerCol  registered one-hot strobe feeding the column's FrameStrobe input.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 err  output  1  sticky out-of-range flag (see Configuration).

Function
REQ-015 FSM states: IDLE, SETUP, STROBE, HOLD.
REQ-016 IDLE: req_ready=1; handshake = req_valid & req_ready at an edge; captures req_frame/req_data, moves to SETUP.
REQ-017 SETUP (1 cycle): FrameData = captured word, FrameStrobe = 0; next STROBE.
REQ-018 STROBE (StrobeWidth cycles, down-counter): FrameStrobe bit req_frame = 1, all others 0; FrameData held; next HOLD.
REQ-019 HOLD (1 cycle): FrameStrobe = 0, FrameData held; next IDLE.
REQ-020 Timing: handshake at edge k -> SETUP after k, strobe high after edges k+1..k+StrobeWidth, HOLD after k+StrobeWidth+1, req_ready=1 after k+StrobeWidth+2.
REQ-021 req_ready SHALL be 0 in SETUP, STROBE, HOLD; req_valid is ignored there; no back-to-back overlap of strobes.
REQ-022 FrameData SHALL keep its last value in IDLE (no return to zero between writes).
REQ-023 FrameStrobe SHALL never have more than one bit set in any cycle.
REQ-024 Out-of-range index (req_frame >= MaxFramesPerCol) SHALL still be accepted and run the full SETUP/STROBE/HOLD timing with FrameStrobe all-zero.
REQ-025 Strobe counter width = clog2(StrobeWidth+1); no wrap-around beyond StrobeWidth.

Reset
REQ-026 Reset high at an edge SHALL force: state IDLE, FrameStrobe=0, FrameData=0, err=0, busy=0, req_ready=1 after that edge.
REQ-027 Reset mid-STROBE SHALL terminate the strobe at that edge; the aborted request is discarded, not replayed.
REQ-028 Reset has priority over a simultaneous handshake.

Configuration
REQ-029 Macro FRAME_STROBE_RANGE_CHECK_EN defined: accepting an out-of-range req_frame sets err=1 on the handshake edge; err stays 1 until Reset.
REQ-030 Macro undefined: err tied 0; out-of-range requests silently produce no strobe per REQ-024.

Structure
REQ-031 Shared package holds the FSM state enum, default MaxFramesPerCol/FrameBitsPerRow/FrameIdxWidth constants.
REQ-032 One sub-module: frame_strobe_dec (registered-output-free index-to-one-hot decoder with range qualify); FSM and counter live in the top.

Verification
REQ-033 Reset, then req_frame=3, req_data=32'hA5A5_0F0F, StrobeWidth=2, handshake edge 0 -> FrameData=A5A50F0F after edge 0; FrameStrobe=20'h00008 after edges 1,2; 0 after 3; req_ready=1 after 4.
REQ-034 req_valid held high continuously with frames 0 then 19 -> two accepted writes 5 cycles apart, strobes 20'h00001 then 20'h80000, never overlapping.
REQ-035 req_frame=25 -> full 5-cycle busy sequence, FrameStrobe all-zero; err=1 with FRAME_STROBE_RANGE_CHECK_EN, err=0 without.
REQ-036 Reset asserted on edge 2 of a strobe to frame 7 -> FrameStrobe=0, FrameData=0, req_ready=1 after that edge; no later strobe.
REQ-037 Reset and req_valid high at the same edge -> no capture, FSM IDLE, FrameStrobe stays 0.
REQ-038 Assertion checker throughout all scenarios: popcount(FrameStrobe) <= 1 and req_ready == !busy.
